// File: rtl/infmnl_pkg.sv
// Shared state encoding, counter width and helpers for the infmnl trigger-out generator.
package infmnl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StActive = 2'd2
    } trig_state_e;

    localparam int unsigned TrigCntW = 16;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/infmnl_trig_downcnt.sv
// Loadable down-counter with zero flag, shared by the delay and pulse-width phases.
module infmnl_trig_downcnt #(
    parameter int unsigned CntW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            dec_i,
    output logic            zero_o
);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/infmnl_trigout_gen.sv
// Delayed, fixed-width trigger pulse generator driven by playback sync or software trigger.
// Define INFMNL_TRIGOUT_RETRIG_EN to restart the sequence on events arriving while busy.
module infmnl_trigout_gen
    import infmnl_pkg::*;
#(
    parameter int unsigned DLY_W = 16,
    parameter int unsigned WID_W = 16
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                Enable,
    input  logic                SyncIn,
    input  logic                SwTrig,
    input  logic [DLY_W-1:0]    DelayCnt,
    input  logic [WID_W-1:0]    WidthCnt,
    input  logic                Polarity,
    output logic                Dout,
    output logic                Busy,
    output logic                Missed,
    output logic [TrigCntW-1:0] TrigCount
);

    localparam int unsigned CntW = max_w(DLY_W, WID_W);

    trig_state_e         state_d, state_q;
    logic [WID_W-1:0]    wid_d, wid_q;
    logic [TrigCntW-1:0] trig_cnt_d, trig_cnt_q;
    logic                pol_d, pol_q;
    logic                dout_d, dout_q;
    logic                missed_d, missed_q;
    logic                armed_q;
    logic                ev, accept, reject, enter_active;
    logic                cnt_ld, cnt_dec, cnt_zero;
    logic [CntW-1:0]     cnt_ld_val;

    // Counter holds cycles remaining minus one, so zero marks the final cycle of a phase.
    function automatic logic [CntW-1:0] width_m1(input logic [WID_W-1:0] w);
        return (w == '0) ? '0 : CntW'(w - WID_W'(1));
    endfunction

    // armed_q blocks events on the first edge after reset release.
    assign ev = armed_q & Enable & (SyncIn | SwTrig);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        reject       = 1'b0;
        enter_active = 1'b0;
        cnt_ld       = 1'b0;
        cnt_ld_val   = '0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            StIdle: accept = ev;
            StDelay: begin
                if (!Enable) begin
                    state_d = StIdle;
                end else if (cnt_zero) begin
                    state_d      = StActive;
                    enter_active = 1'b1;
                    cnt_ld       = 1'b1;
                    cnt_ld_val   = width_m1(wid_q);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StActive: begin
                if (!Enable) begin
                    state_d = StIdle;
                end else if (cnt_zero) begin
                    state_d = StIdle;
                    accept  = ev;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (ev && (state_q != StIdle) && !accept) begin
`ifdef INFMNL_TRIGOUT_RETRIG_EN
            accept = 1'b1;
`else
            reject = 1'b1;
`endif
        end
        if (accept) begin
            cnt_ld  = 1'b1;
            cnt_dec = 1'b0;
            if (DelayCnt == '0) begin
                state_d      = StActive;
                enter_active = 1'b1;
                cnt_ld_val   = width_m1(WidthCnt);
            end else begin
                state_d      = StDelay;
                enter_active = 1'b0;
                cnt_ld_val   = CntW'(DelayCnt - DLY_W'(1));
            end
        end
    end

    // Idle output follows the live Polarity input; a running sequence uses the latched value.
    always_comb begin
        wid_d      = accept ? WidthCnt : wid_q;
        pol_d      = (accept || (state_d == StIdle)) ? Polarity : pol_q;
        dout_d     = pol_d ^ (state_d == StActive);
        missed_d   = reject;
        trig_cnt_d = enter_active ? trig_cnt_q + TrigCntW'(1) : trig_cnt_q;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wid_q      <= '0;
            pol_q      <= 1'b0;
            dout_q     <= 1'b0;
            missed_q   <= 1'b0;
            trig_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            wid_q      <= wid_d;
            pol_q      <= pol_d;
            dout_q     <= dout_d;
            missed_q   <= missed_d;
            trig_cnt_q <= trig_cnt_d;
            armed_q    <= 1'b1;
        end
    end

    infmnl_trig_downcnt #(
        .CntW(CntW)
    ) u_downcnt (
        .clk_i     (Clock),
        .rst_ni    (nReset),
        .load_i    (cnt_ld),
        .load_val_i(cnt_ld_val),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    assign Dout      = dout_q;
    assign Busy      = (state_q != StIdle);
    assign Missed    = missed_q;
    assign TrigCount = trig_cnt_q;

endmodule

// File: tb/tb_infmnl_trigout_gen.sv
// Directed and randomized checks of infmnl_trigout_gen against a pulse-window reference model.
module tb_infmnl_trigout_gen;

`ifdef INFMNL_TRIGOUT_RETRIG_EN
    localparam bit Retrig = 1'b1;
`else
    localparam bit Retrig = 1'b0;
`endif

    logic        Clock, nReset, Enable, SyncIn, SwTrig, Polarity;
    logic [15:0] DelayCnt, WidthCnt;
    logic        Dout, Busy, Missed;
    logic [15:0] TrigCount;

    int vecs;
    int errs;

    // Reference model: each accepted event defines a pulse window [m_start, m_end].
    int unsigned t;
    int unsigned m_start, m_end;
    bit          m_job, m_pol_l, m_armed;
    logic [15:0] m_cnt;

    infmnl_trigout_gen #(
        .DLY_W(16),
        .WID_W(16)
    ) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .Enable   (Enable),
        .SyncIn   (SyncIn),
        .SwTrig   (SwTrig),
        .DelayCnt (DelayCnt),
        .WidthCnt (WidthCnt),
        .Polarity (Polarity),
        .Dout     (Dout),
        .Busy     (Busy),
        .Missed   (Missed),
        .TrigCount(TrigCount)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock with the inputs currently applied and check against the model.
    task automatic cycle();
        bit          ev, busy_t, last_t, miss, e_dout;
        int unsigned w;
        busy_t = m_job && (t <= m_end);
        last_t = busy_t && (t == m_end);
        ev     = m_armed && Enable && (SyncIn || SwTrig);
        miss   = 1'b0;
        if (busy_t && !Enable) begin
            m_job = 1'b0;
        end else if (ev) begin
            if (!busy_t || last_t || Retrig) begin
                w       = (WidthCnt == 16'd0) ? 1 : int'(WidthCnt);
                m_job   = 1'b1;
                m_start = t + 1 + DelayCnt;
                m_end   = t + DelayCnt + w;
                m_pol_l = Polarity;
            end else begin
                miss = 1'b1;
            end
        end
        m_armed = 1'b1;
        t++;
        if (m_job && (t > m_end)) m_job = 1'b0;
        if (m_job && (t == m_start)) m_cnt++;
        if (!m_job) e_dout = Polarity;
        else e_dout = (t >= m_start) ? !m_pol_l : m_pol_l;
        @(posedge Clock);
        #1;
        chk("dout", 32'(Dout), 32'(e_dout));
        chk("busy", 32'(Busy), 32'(m_job));
        chk("missed", 32'(Missed), 32'(miss));
        chk("trig_count", 32'(TrigCount), 32'(m_cnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, 32'(Dout), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_missed"}, 32'(Missed), 32'd0);
        chk({tag, "_cnt"}, 32'(TrigCount), 32'd0);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        #1;
        m_job   = 1'b0;
        m_armed = 1'b0;
        m_cnt   = 16'd0;
        chk_zero("rst_async");
        @(posedge Clock);
        #1;
        t++;
        chk_zero("rst_held");
        nReset = 1'b1;
    endtask

    initial begin
        int          first, misses;
        logic [15:0] c0;
        vecs = 0;
        errs = 0;
        t = 0;
        m_start = 0;
        m_end = 0;
        m_pol_l = 1'b0;
        m_job = 1'b0;
        m_armed = 1'b0;
        m_cnt = 16'd0;
        nReset = 1'b0;
        Enable = 1'b0;
        SyncIn = 1'b0;
        SwTrig = 1'b0;
        Polarity = 1'b0;
        DelayCnt = 16'd0;
        WidthCnt = 16'd0;
        #2;
        do_reset();

        // D=0, W=1, active-high: one-cycle pulse right after the event.
        Enable = 1'b1;
        DelayCnt = 16'd0;
        WidthCnt = 16'd1;
        run(9);
        SyncIn = 1'b1;
        cycle();
        SyncIn = 1'b0;
        chk("a_dout_on", 32'(Dout), 32'd1);
        chk("a_cnt", 32'(TrigCount), 32'd1);
        cycle();
        chk("a_dout_off", 32'(Dout), 32'd0);

        // D=5, W=3, active-low; inputs scrambled after the event must not matter.
        Polarity = 1'b1;
        run(2);
        SwTrig = 1'b1;
        DelayCnt = 16'd5;
        WidthCnt = 16'd3;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            SwTrig = 1'b0;
            DelayCnt = 16'($urandom_range(0, 9));
            WidthCnt = 16'($urandom_range(0, 9));
            chk("b_dout", 32'(Dout), ((i >= 6) && (i <= 8)) ? 32'd0 : 32'd1);
            chk("b_busy", 32'(Busy), (i <= 8) ? 32'd1 : 32'd0);
        end

        // Second event two cycles into a D=4, W=4 sequence.
        Polarity = 1'b0;
        DelayCnt = 16'd4;
        WidthCnt = 16'd4;
        run(2);
        c0 = m_cnt;
        first = 0;
        misses = 0;
        SyncIn = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            SyncIn = (i == 2);
            if (Dout && (first == 0)) first = i;
            if (Missed) misses++;
        end
        chk("c_first_active", 32'(first), Retrig ? 32'd7 : 32'd5);
        chk("c_missed_pulses", 32'(misses), Retrig ? 32'd0 : 32'd1);
        chk("c_trig_count", 32'(TrigCount), 32'(c0 + 16'd1));

        // Enable dropped in the 2nd active cycle of a W=10 pulse.
        DelayCnt = 16'd0;
        WidthCnt = 16'd10;
        SyncIn = 1'b1;
        cycle();
        SyncIn = 1'b0;
        c0 = m_cnt;
        cycle();
        Enable = 1'b0;
        cycle();
        chk("d_dout", 32'(Dout), 32'd0);
        chk("d_busy", 32'(Busy), 32'd0);
        chk("d_cnt", 32'(TrigCount), 32'(c0));
        Enable = 1'b1;
        run(3);

        // TrigCount wrap via back-to-back D=0, W=1 pulses.
        do_reset();
        DelayCnt = 16'd0;
        WidthCnt = 16'd1;
        SyncIn = 1'b1;
        run(65536);
        chk("e_cnt_max", 32'(TrigCount), 32'h0000_FFFF);
        cycle();
        chk("e_cnt_wrap", 32'(TrigCount), 32'd0);
        SyncIn = 1'b0;
        run(3);

        // Event on the last width cycle gives a gapless second pulse.
        WidthCnt = 16'd3;
        SyncIn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            SyncIn = (i == 3);
            if (i == 3) WidthCnt = 16'd2;
            chk("e_gapless", 32'(Dout), (i <= 5) ? 32'd1 : 32'd0);
        end

        // Reset asserted mid-delay, then an event on the first edge after release.
        DelayCnt = 16'd20;
        WidthCnt = 16'd2;
        SyncIn = 1'b1;
        cycle();
        SyncIn = 1'b0;
        run(3);
        do_reset();
        DelayCnt = 16'd0;
        SyncIn = 1'b1;
        cycle();
        SyncIn = 1'b0;
        chk("f_busy_ignored", 32'(Busy), 32'd0);
        chk("f_dout_ignored", 32'(Dout), 32'd0);
        run(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            Enable = ($urandom_range(0, 15) != 0);
            SyncIn = ($urandom_range(0, 5) == 0);
            SwTrig = ($urandom_range(0, 7) == 0);
            DelayCnt = 16'($urandom_range(0, 5));
            WidthCnt = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) Polarity = ~Polarity;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/infmnl_trigout_gen.md
INFMNL_TRIGOUT_GEN -- requirements
Module: infmnl_trigout_gen

Interface
REQ-001 SHALL have parameter DLY_W, default 16, width of the delay count.
REQ-002 SHALL have parameter WID_W, default 16, width of the pulse-width count.
REQ-003 SHALL have port Clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port nReset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Enable, input, 1, generator enable.
REQ-006 SHALL have port SyncIn, input, 1, one-cycle waveform-start pulse from playback.
REQ-007 SHALL have port SwTrig, input, 1, one-cycle software trigger.
REQ-008 SHALL have port DelayCnt, input, DLY_W, cycles from event to pulse start.
REQ-009 SHALL have port WidthCnt, input, WID_W, pulse width in cycles.
REQ-010 SHALL have port Polarity, input, 1, where 1 means active-low output.
REQ-011 SHALL have port Dout, output, 1, registered trigger, feeding the trigger-out latency path Din.
REQ-012 SHALL have port Busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port Missed, output, 1, one-cycle flag for a rejected event.
REQ-014 SHALL have port TrigCount, output, 16, count of pulses started.

Function
REQ-015 SHALL form event = Enable & (SyncIn | SwTrig); simultaneous SyncIn and SwTrig are one event.
REQ-016 SHALL implement FSM states IDLE, DELAY and ACTIVE.
REQ-017 SHALL, on an event in IDLE, latch DelayCnt, WidthCnt and Polarity; later changes to these inputs have no effect until the next accepted event.
REQ-018 SHALL, on an event in IDLE with DelayCnt=0, go to ACTIVE; with DelayCnt=D>0, go to DELAY and count D cycles, then go to ACTIVE.
REQ-019 SHALL remain in ACTIVE for exactly W=WidthCnt cycles, with W=0 treated as 1, then return to IDLE.
REQ-020 SHALL drive Dout = latched Polarity XOR (state==ACTIVE), registered.
REQ-021 SHALL, for an event in cycle N, assert Dout active during cycles N+1+D through N+D+W inclusive.
REQ-022 SHALL, when no pulse is active, drive Dout to the current Polarity inactive level (1 if Polarity=1, else 0).
REQ-023 SHALL increment TrigCount by 1 on each entry to ACTIVE; TrigCount wraps from 0xFFFF to 0.
REQ-024 SHALL allow an event in the cycle ACTIVE ends (the last width cycle) to be accepted as a new IDLE event, giving back-to-back pulses with no inactive gap.
REQ-025 SHALL, on Enable deassertion in DELAY or ACTIVE, return to IDLE on the next edge, drive Dout inactive from that edge, and leave TrigCount unchanged.
REQ-026 SHALL assert Missed for one cycle for an event arriving in DELAY, or in ACTIVE before its last cycle, and otherwise ignore that event (default build).

Reset
REQ-027 SHALL, while nReset=0, asynchronously force state=IDLE, Dout=0, Busy=0, Missed=0, TrigCount=0 and latched Polarity=0.
REQ-028 SHALL apply reset asserted mid-pulse immediately, with no completion of the pulse.
REQ-029 SHALL accept no event in the first edge after nReset release.

Configuration
REQ-030 SHALL, with macro INFMNL_TRIGOUT_RETRIG_EN defined, treat an event in DELAY or ACTIVE as a restart: relatch the inputs, begin the sequence as if from IDLE, keep Missed=0, and increment TrigCount again at the next ACTIVE entry.
REQ-031 SHALL, without INFMNL_TRIGOUT_RETRIG_EN, behave per REQ-026.

Structure
REQ-032 SHALL place the state enumeration (IDLE/DELAY/ACTIVE encoding) and the TrigCount width constant (16) in the shared infmnl package.
REQ-033 SHALL implement the delay and width down-counter as one sub-module, infmnl_trig_downcnt (load, decrement, zero flag), instantiated once and reused across DELAY and ACTIVE.

Verification
REQ-034 SHALL cover: SyncIn at cycle 10, D=0, W=1, Polarity=0 -> Dout=1 in cycle 11 only; TrigCount=1.
REQ-035 SHALL cover: SwTrig at cycle 10, D=5, W=3, Polarity=1 -> Dout=0 in cycles 16-18 and 1 elsewhere; Busy high in cycles 11-18.
REQ-036 SHALL cover: D=4, W=4, second event 2 cycles after the first -> default build: Missed pulses once, one pulse; RETRIG build: the pulse starts at second event+5, TrigCount=1.
REQ-037 SHALL cover: Enable dropped in the 2nd ACTIVE cycle of W=10 -> Dout inactive from the next edge, Busy=0, TrigCount unchanged.
REQ-038 SHALL cover: TrigCount preset near 0xFFFF via 65536 pulses with D=0, W=1 -> the count reads 0 after wrap; an event on the last width cycle yields a gapless second pulse.
REQ-039 SHALL cover: nReset asserted mid-DELAY -> all outputs 0 immediately; an event on the first edge after release is ignored.
